// File: rtl/alu_cmd_queue_if.sv
// rtl/alu_cmd_queue_if.sv - command, ALU and result signals of the ALU command queue
interface alu_cmd_queue_if #(
    parameter int PTRW = 2
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [15:0]     in_a;
    logic [15:0]     in_b;
    logic [1:0]      alu_op;
    logic [15:0]     alu_a;
    logic [15:0]     alu_b;
    logic [15:0]     alu_out;
    logic            alu_co;
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_data;
    logic            res_co;
    logic            res_zero;
    logic [1:0]      res_op;
    logic [PTRW:0]   count;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_out, alu_co, res_ready,
        output in_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_co,
               res_zero, res_op, count
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_out, alu_co, res_ready,
        input  in_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_co,
               res_zero, res_op, count
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO feeding an external ALU, with a registered result port
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_queue_if.slave    bus
);
    localparam logic [PTRW:0] DEPTH_C = DEPTH[PTRW:0];

    logic [1:0]  op_mem [DEPTH];
    logic [15:0] a_mem  [DEPTH];
    logic [15:0] b_mem  [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic            res_valid_q, res_valid_d;
    logic [15:0]     res_data_q, res_data_d;
    logic            res_co_q, res_co_d;
    logic            res_zero_q, res_zero_d;
    logic [1:0]      res_op_q, res_op_d;

    logic not_empty;
    logic push;
    logic cap;

    assign not_empty = (count_q != '0);
    assign push      = bus.in_valid && (count_q < DEPTH_C);
    assign cap       = not_empty && (!res_valid_q || bus.res_ready);

    // Head entry goes straight to the ALU; zeroed while empty so the ALU sees a quiet input
    assign bus.alu_op = not_empty ? op_mem[rd_ptr_q] : 2'b00;
    assign bus.alu_a  = not_empty ? a_mem[rd_ptr_q]  : 16'h0000;
    assign bus.alu_b  = not_empty ? b_mem[rd_ptr_q]  : 16'h0000;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_co_d    = res_co_q;
        res_zero_d  = res_zero_q;
        res_op_d    = res_op_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (cap) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = bus.alu_out;
            res_co_d    = (bus.alu_op == 2'b11) ? 1'b0 : bus.alu_co;
            res_zero_d  = (bus.alu_out == 16'h0000);
            res_op_d    = bus.alu_op;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        if (push && !cap) begin
            count_d = count_q + 1'b1;
        end else if (!push && cap) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_co_q    <= 1'b0;
            res_zero_q  <= 1'b0;
            res_op_q    <= 2'b00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_co_q    <= res_co_d;
            res_zero_q  <= res_zero_d;
            res_op_q    <= res_op_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= bus.in_op;
            a_mem[wr_ptr_q]  <= bus.in_a;
            b_mem[wr_ptr_q]  <= bus.in_b;
        end
    end

    assign bus.in_ready  = (count_q < DEPTH_C);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_co    = res_co_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_op    = res_op_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - randomized self-checking bench for alu_cmd_queue
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic xor_junk_co = 1'b0;

    alu_cmd_queue_if #(.PTRW(PTRW)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // {co,out} of the ALU; for xor the result port must report co 0
    function automatic logic [16:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            2'b00: alu_ref = 17'(ua + ub);
            2'b01: alu_ref = {ua < ub, 16'(ua - ub)};
            2'b10: alu_ref = {ua == 0, 16'(65536 - ua)};
            default: alu_ref = {1'b0, a ^ b};
        endcase
    endfunction

    // External ALU: for xor it drives a junk carry the queue must ignore
    always_comb begin
        logic [16:0] r;
        r = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_out = r[15:0];
        bus.alu_co  = (bus.alu_op == 2'b11) ? xor_junk_co : r[16];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue of pending commands plus the held result
    logic [33:0] m_q[$];
    logic        m_rv;
    logic [15:0] m_data;
    logic        m_co;
    logic        m_zero;
    logic [1:0]  m_op;

    task automatic model_reset();
        m_q.delete();
        m_rv = 1'b0; m_data = 16'h0; m_co = 1'b0; m_zero = 1'b0; m_op = 2'b00;
    endtask

    task automatic check_all();
        logic [33:0] h;
        check("count", 32'(bus.count), 32'(m_q.size()));
        check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
        check("res_valid", 32'(bus.res_valid), 32'(m_rv));
        check("res_data", 32'(bus.res_data), 32'(m_data));
        check("res_co", 32'(bus.res_co), 32'(m_co));
        check("res_zero", 32'(bus.res_zero), 32'(m_zero));
        check("res_op", 32'(bus.res_op), 32'(m_op));
        h = (m_q.size() != 0) ? m_q[0] : 34'h0;
        check("alu_head", {bus.alu_op, bus.alu_a[13:0], bus.alu_b}, {h[33:32], h[29:16], h[15:0]});
        check("alu_a", 32'(bus.alu_a), 32'(h[31:16]));
    endtask

    // One clock: drive inputs after a negedge, advance the model, check at the next negedge
    task automatic step(input logic v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic rr, output logic accepted);
        logic push, cap;
        logic [33:0] e;
        logic [16:0] r;
        bus.in_valid = v; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.res_ready = rr;
        xor_junk_co = 1'($urandom);
        #1;
        push = v && (m_q.size() < DEPTH);
        cap  = (m_q.size() != 0) && (!m_rv || rr);
        if (cap) begin
            e = m_q.pop_front();
            r = alu_ref(e[33:32], e[31:16], e[15:0]);
            m_rv = 1'b1; m_data = r[15:0]; m_co = r[16]; m_zero = (r[15:0] == 16'h0); m_op = e[33:32];
        end else if (m_rv && rr) begin
            m_rv = 1'b0;
        end
        if (push) m_q.push_back({op, a, b});
        accepted = push;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        check_all();
    endtask

    logic acc;
    logic       cur_v;
    logic [1:0] cur_op;
    logic [15:0] cur_a, cur_b;

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = 16'h0; bus.in_b = 16'h0; bus.res_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Test 1: add with carry out and zero result, one-edge latency
        step(1'b1, 2'b00, 16'h0001, 16'hFFFF, 1'b0, acc);
        check("t1_count", 32'(bus.count), 32'd1);
        check("t1_valid_early", 32'(bus.res_valid), 32'd0);
        step(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, acc);
        check("t1_res", {bus.res_valid, bus.res_co, bus.res_zero, bus.res_data}, {1'b1, 1'b1, 1'b1, 16'h0000});
        step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);

        // Tests 2-4: sub with borrow, negate edge cases, xor with junk carry
        step(1'b1, 2'b01, 16'h0005, 16'h0006, 1'b1, acc);
        step(1'b1, 2'b10, 16'h0000, 16'h1234, 1'b1, acc);
        check("t2_res", {bus.res_co, bus.res_zero, bus.res_data}, {1'b1, 1'b0, 16'hFFFF});
        step(1'b1, 2'b10, 16'h0001, 16'h4321, 1'b1, acc);
        check("t3a_res", {bus.res_co, bus.res_data}, {1'b1, 16'h0000});
        step(1'b1, 2'b11, 16'h0005, 16'h0003, 1'b1, acc);
        check("t3b_res", {bus.res_co, bus.res_data}, {1'b0, 16'hFFFF});
        step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);
        check("t4_res", {bus.res_op, bus.res_co, bus.res_data}, {2'b11, 1'b0, 16'h0006});

        // Test 5: fill under back-pressure, then drain through the pointer wrap
        for (int i = 0; i < 5; i++)
            step(1'b1, 2'(i), 16'(i * 16'h1111), 16'(16'h0F0F + i), 1'b0, acc);
        check("t5_count", 32'(bus.count), 32'd4);
        check("t5_in_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 2'b00, 16'hAAAA, 16'h5555, 1'b0, acc);
        check("t5_full_reject", 32'(acc), 32'd0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);

        // Test 6: asynchronous reset with a full-ish queue and a held result
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i + 1), 16'($urandom), 16'($urandom), 1'b0, acc);
        check("t6_pre", {bus.res_valid, 3'(bus.count)}, {1'b1, 3'd3});
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'b00, 16'h0, 16'h0, 1'b1, acc);

        // Randomized traffic; producer holds a command until it is accepted
        cur_v = 1'b0; cur_op = 2'b00; cur_a = 16'h0; cur_b = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!cur_v && ($urandom_range(0, 3) != 0)) begin
                cur_v  = 1'b1;
                cur_op = 2'($urandom);
                cur_a  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                cur_b  = ($urandom_range(0, 7) == 0) ? cur_a : 16'($urandom);
            end
            step(cur_v, cur_op, cur_a, cur_b, $urandom_range(0, 9) < 6, acc);
            if (acc) cur_v = 1'b0;
            if (n == 200) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
